uart_cmd_decoder: RTL and testbench

- Sits directly downstream of the UART receiver and upstream of the Pong game logic and the switch-debounce outputs.
- Parses the received byte stream (data-valid strobe plus byte) into framed 4-byte commands.
- Validates each frame and drives the game-control strobes and paddle-hold levels that the Pong top consumes.
- Lets a host PC start, pause and drive paddles over the serial link.

---
 rtl/uart_cmd_decoder.sv | 171 +++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Command-frame decoder sitting between the UART receiver and the Pong game logic.
// It parses framed commands of the form SYNC, CMD, ARG, CHK, validates them, and
// drives the game-control strobes and the per-player paddle-hold levels.
//   i_Clk, i_Rst_L        clock, asynchronous active-low reset
//   i_RX_DV, i_RX_Byte    received-byte strobe and data
//   o_Game_Start          one-cycle pulse (cmd 0x01)
//   o_Pause               level, toggled by cmd 0x02
//   o_Score_Clear         one-cycle pulse (cmd 0x03)
//   o_Paddle_{Up,Dn}_P1   P1 hold levels (cmd 0x10 / 0x11, ARG units)
//   o_Paddle_{Up,Dn}_P2   P2 hold levels (cmd 0x20 / 0x21, ARG units)
//   o_Frame_DV            one-cycle pulse per accepted frame
//   o_Err_Count           saturating count of rejected or timed-out frames
module uart_cmd_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS   = 21700,
  parameter int unsigned HOLD_UNIT_CLKS = 25000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Game_Start,
  output logic       o_Pause,
  output logic       o_Score_Clear,
  output logic       o_Paddle_Up_P1,
  output logic       o_Paddle_Dn_P1,
  output logic       o_Paddle_Up_P2,
  output logic       o_Paddle_Dn_P2,
  output logic       o_Frame_DV,
  output logic [7:0] o_Err_Count
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned PRE_W = $clog2(HOLD_UNIT_CLKS + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(HOLD_UNIT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, GET_CMD, GET_ARG, GET_CHK} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, arg_q;
  logic [TMR_W-1:0] tmr_q;
  logic             timeout_c;

  logic       frame_ok_c, frame_err_c, start_c, pause_c, clear_c;
  logic [1:0] load_c, load_dn_c;

  logic [7:0]       units_q [2];
  logic [PRE_W-1:0] pre_q   [2];
  logic             up_q    [2];
  logic             dn_q    [2];

  // A DV on the expiry cycle wins over the timeout.
  assign timeout_c = (state_q != IDLE) && !i_RX_DV && (tmr_q == TMR_LAST);

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; SYNC inside a frame is plain data (no resync)
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) state_d = GET_CMD;
      GET_CMD: if (i_RX_DV) state_d = GET_ARG; else if (timeout_c) state_d = IDLE;
      GET_ARG: if (i_RX_DV) state_d = GET_CHK; else if (timeout_c) state_d = IDLE;
      GET_CHK: if (i_RX_DV || timeout_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame evaluation on the CHK byte's DV; results are registered below
  always_comb begin
    frame_ok_c  = 1'b0;
    frame_err_c = timeout_c;
    start_c     = 1'b0;
    pause_c     = 1'b0;
    clear_c     = 1'b0;
    load_c      = 2'b00;
    load_dn_c   = 2'b00;
    if ((state_q == GET_CHK) && i_RX_DV) begin
      if (i_RX_Byte != (cmd_q ^ arg_q)) begin
        frame_err_c = 1'b1;
      end else begin
        frame_ok_c = 1'b1;
        case (cmd_q)
          8'h01:   start_c = 1'b1;
          8'h02:   pause_c = 1'b1;
          8'h03:   clear_c = 1'b1;
          8'h10:   load_c[0] = 1'b1;
          8'h11:   begin load_c[0] = 1'b1; load_dn_c[0] = 1'b1; end
          8'h20:   load_c[1] = 1'b1;
          8'h21:   begin load_c[1] = 1'b1; load_dn_c[1] = 1'b1; end
          default: begin frame_ok_c = 1'b0; frame_err_c = 1'b1; end
        endcase
      end
    end
  end

  // Byte capture and inter-byte timer
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cmd_q <= 8'd0;
      arg_q <= 8'd0;
      tmr_q <= '0;
    end else begin
      if (i_RX_DV && (state_q == GET_CMD)) cmd_q <= i_RX_Byte;
      if (i_RX_DV && (state_q == GET_ARG)) arg_q <= i_RX_Byte;
      if (i_RX_DV || (state_q == IDLE) || timeout_c) tmr_q <= '0;
      else                                           tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  // Registered strobes, pause level and saturating error counter
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Frame_DV    <= 1'b0;
      o_Game_Start  <= 1'b0;
      o_Score_Clear <= 1'b0;
      o_Pause       <= 1'b0;
      o_Err_Count   <= 8'd0;
    end else begin
      o_Frame_DV    <= frame_ok_c;
      o_Game_Start  <= start_c;
      o_Score_Clear <= clear_c;
      if (pause_c) o_Pause <= ~o_Pause;
      if (frame_err_c && (o_Err_Count != 8'hFF)) o_Err_Count <= o_Err_Count + 8'd1;
    end
  end

  // Paddle-hold engines, one per player; a load always replaces the running hold
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int p = 0; p < 2; p++) begin
        units_q[p] <= 8'd0;
        pre_q[p]   <= '0;
        up_q[p]    <= 1'b0;
        dn_q[p]    <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (load_c[p]) begin
          units_q[p] <= arg_q;
          pre_q[p]   <= '0;
          up_q[p]    <= (arg_q != 8'd0) && !load_dn_c[p];
          dn_q[p]    <= (arg_q != 8'd0) && load_dn_c[p];
        end else if (units_q[p] != 8'd0) begin
          if (pre_q[p] == PRE_LAST) begin
            pre_q[p]   <= '0;
            units_q[p] <= units_q[p] - 8'd1;
            // Last unit expiring: release both levels
            if (units_q[p] == 8'd1) begin
              up_q[p] <= 1'b0;
              dn_q[p] <= 1'b0;
            end
          end else begin
            pre_q[p] <= pre_q[p] + PRE_W'(1);
          end
        end
      end
    end
  end

  assign o_Paddle_Up_P1 = up_q[0];
  assign o_Paddle_Dn_P1 = dn_q[0];
  assign o_Paddle_Up_P2 = up_q[1];
  assign o_Paddle_Dn_P2 = dn_q[1];

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: table-driven frames with a
// cycle-tagged scoreboard, plus hand-written paddle, timeout, reset and
// saturation sequences.
module tb_uart_cmd_decoder;

  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned HOLD    = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] rx = 8'd0;
  logic       game_start, pause, score_clear, up1, dn1, up2, dn2, frame_dv;
  logic [7:0] err_count;

  uart_cmd_decoder #(
    .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TIMEOUT), .HOLD_UNIT_CLKS(HOLD)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(dv), .i_RX_Byte(rx),
    .o_Game_Start(game_start), .o_Pause(pause), .o_Score_Clear(score_clear),
    .o_Paddle_Up_P1(up1), .o_Paddle_Dn_P1(dn1),
    .o_Paddle_Up_P2(up2), .o_Paddle_Dn_P2(dn2),
    .o_Frame_DV(frame_dv), .o_Err_Count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       dv, start, clear, pause;
    logic [7:0] err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] cmd, arg, chk;
    logic       dv, start, clear, tog, err_inc;
  } vec_t;
  vec_t vecs[9];

  logic       exp_pause = 1'b0;
  logic [7:0] exp_err   = 8'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: compare due expectations, otherwise require pulses to be idle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      chk("sb_missed_due", cyc, e.due);
    end
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("frame_dv", int'(frame_dv), int'(e.dv));
      chk("game_start", int'(game_start), int'(e.start));
      chk("score_clear", int'(score_clear), int'(e.clear));
      chk("pause", int'(pause), int'(e.pause));
      chk("err_count", int'(err_count), int'(e.err));
    end else begin
      chk("idle_pulses", int'({frame_dv, game_start, score_clear}), 0);
    end
  end

  task automatic send_byte(input logic [7:0] b, output int at);
    @(posedge clk); #1;
    rx = b; dv = 1'b1; at = cyc;
    @(posedge clk); #1;
    dv = 1'b0;
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Sends one full frame and schedules its expected effects for the cycle after CHK
  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k,
                            input logic e_dv, input logic e_start, input logic e_clear,
                            input logic e_tog, input logic e_err);
    int at;
    send_byte(8'hA5, at);
    send_byte(c, at);
    send_byte(a, at);
    send_byte(k, at);
    if (e_err) exp_err = sat_inc(exp_err);
    if (e_tog) exp_pause = ~exp_pause;
    sb.push_back('{due: at + 1, dv: e_dv, start: e_start, clear: e_clear,
                   pause: exp_pause, err: exp_err});
  endtask

  initial begin
    int at, n_up, n_dn, n_oth, first_up, last_up;

    //               cmd    arg    chk    dv    start clear tog   err
    vecs[0] = '{8'h01, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h7F, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h02, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h02, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h03, 8'h55, 8'h56, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 8'hA5, 8'hA4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'h10, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({game_start, pause, score_clear, up1, dn1, up2, dn2,
                               frame_dv, err_count}), 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      send_frame(vecs[i].cmd, vecs[i].arg, vecs[i].chk, vecs[i].dv, vecs[i].start,
                 vecs[i].clear, vecs[i].tog, vecs[i].err_inc);
    repeat (4) @(posedge clk);

    // P1 up for 3 units = 30 cycles, P2 untouched
    send_frame(8'h10, 8'h03, 8'h13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_up = 0; n_dn = 0; n_oth = 0; first_up = -1; last_up = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (up1) begin n_up++; if (first_up < 0) first_up = i; last_up = i; end
      if (dn1) n_dn++;
      if (up2 || dn2) n_oth++;
    end
    chk("p1_up_cycles", n_up, 30);
    chk("p1_up_first", first_up, 0);
    chk("p1_up_last", last_up, 29);
    chk("p1_dn_cycles", n_dn, 0);
    chk("p2_during_p1", n_oth, 0);

    // P2 down, then replaced by P2 up for 2 units
    send_frame(8'h21, 8'h05, 8'h24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("p2_dn_held", int'({up2, dn2}), 1);
    send_frame(8'h20, 8'h02, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_up = 0; n_dn = 0; n_oth = 0; first_up = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) chk("p2_swap_edge", int'({up2, dn2}), 2);
      if (up2) n_up++;
      if (dn2) n_dn++;
      if (up1 || dn1) n_oth++;
    end
    chk("p2_up_cycles", n_up, 20);
    chk("p2_dn_after_swap", n_dn, 0);
    chk("p1_during_p2", n_oth, 0);

    // P2 cancel with ARG=0 must not disturb a running P1 hold
    send_frame(8'h11, 8'h04, 8'h15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h21, 8'h05, 8'h24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h20, 8'h00, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("p2_cancel", int'({up2, dn2}), 0);
    chk("p1_kept", int'({up1, dn1}), 1);
    repeat (45) @(posedge clk);

    // Timeout in GET_ARG: error lands TIMEOUT cycles after the last DV
    send_byte(8'hA5, at);
    send_byte(8'h03, at);
    sb.push_back('{due: at + int'(TIMEOUT), dv: 1'b0, start: 1'b0, clear: 1'b0,
                   pause: exp_pause, err: exp_err});
    exp_err = sat_inc(exp_err);
    sb.push_back('{due: at + int'(TIMEOUT) + 1, dv: 1'b0, start: 1'b0, clear: 1'b0,
                   pause: exp_pause, err: exp_err});
    repeat (TIMEOUT + 5) @(posedge clk);
    send_frame(8'h03, 8'h00, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-hold and mid-frame
    send_frame(8'h02, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h10, 8'h05, 8'h15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'hA5, at);
    send_byte(8'h01, at);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({game_start, pause, score_clear, up1, dn1, up2, dn2,
                                     frame_dv, err_count}), 0);
    sb.delete();
    exp_err = 8'd0;
    exp_pause = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_byte(8'h00, at);
    send_byte(8'h01, at);
    repeat (4) @(negedge clk);
    chk("no_partial_frame", int'({err_count, up1, dn1}), 0);

    // 300 bad frames saturate the error counter
    for (int i = 0; i < 300; i++)
      send_frame(8'h02, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("err_saturated", int'(err_count), 255);

    repeat (4) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
